// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side streaming stage.
// Used by fifo_rd_stream and fifo_rd_skid.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int SKID_DEPTH_DEF = 3;
  localparam int PKT_LEN_DEF    = 4;
  localparam int STATS_W        = 32;

endpackage

// File: rtl/fifo_rd_skid.sv
// In-order skid buffer that absorbs words landing from the FIFO's registered read port.
// Storage is not reset; only the pointers and occupancy count are.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  localparam int CW = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(SKID_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(SKID_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [SKID_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt_ptr(wr_ptr);
      if (pop)  rd_ptr <= nxt_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO into a valid/ready stream with packet framing (m_last).
// Optional FIFO_RD_STREAM_STATS_EN adds word_cnt / stall_cnt outputs.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int PKT_LEN    = PKT_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0]    word_cnt,
  output logic [STATS_W-1:0]    stall_cnt
`endif
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(SKID_DEPTH);
  localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic [PW-1:0]         pkt_cnt;
  logic                  push;
  logic                  pop;
  logic [FIFO_WIDTH-1:0] head_data;

  // Reads are gated on committed occupancy only, so m_ready never reaches fifo_rd_en.
  assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (occ < DEPTH_V);

  assign push    = inflight && !fifo_underflow;
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // Buffer storage is never reset; an empty buffer presents zeros instead.
  assign m_data  = m_valid ? head_data : '0;
  assign m_last  = m_valid && (pkt_cnt == PKT_MAX);
  assign busy    = inflight || m_valid;

  fifo_rd_skid #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      err      <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (inflight && fifo_underflow) err <= 1'b1;
      if (pop) pkt_cnt <= (pkt_cnt == PKT_MAX) ? '0 : pkt_cnt + PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = busy ? DRAIN : IDLE;
      DRAIN: begin
        if (en)         state_nxt = RUN;
        else if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) word_cnt <= word_cnt + STATS_W'(1);
      if (m_valid && !m_ready) stall_cnt <= stall_cnt + STATS_W'(1);
    end
  end
`endif

endmodule
